binary_to_bcd_seq: RTL and testbench



---
 rtl/bcd_pkg.sv | 26 ++
 rtl/bcd_add3_digit.sv | 15 +
 rtl/binary_to_bcd_seq.sv | 92 +++++++++
 tb/tb_binary_to_bcd_seq.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_pkg
// Brief    : Shared types and constants for the sequential binary-to-BCD path.
// Revision : 1.0
// ============================================================================
package bcd_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_DIGITS = 3;

  // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
  localparam int DEF_CNT_W  = $clog2(DEF_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_add3_digit.sv
`default_nettype none
// ============================================================================
// Module   : bcd_add3_digit
// Brief    : Double-dabble digit correction, adds 3 when the digit is >= 5.
// Revision : 1.0
// ============================================================================
module bcd_add3_digit (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule
`default_nettype wire

// File: rtl/binary_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : binary_to_bcd_seq
// Brief    : Multi-cycle shift-and-add-3 converter with start/busy/done handshake.
// Revision : 1.0
// ============================================================================
module binary_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WIDTH-1:0]    bin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam int BCD_W = 4 * DIGITS;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]         shift_q, shift_d;
  logic [BCD_W-1:0]         scratch_q, scratch_d;
  logic [BCD_W-1:0]         bcd_q, bcd_d;
  logic [BCD_W-1:0]         adj;
  logic [BCD_W+WIDTH-1:0]   shifted;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .digit_i (scratch_q[4*g +: 4]),
      .digit_o (adj[4*g +: 4])
    );
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    bcd_d     = bcd_q;
    // Correct first, then shift: the MSB of the binary operand enters the scratch LSB.
    shifted   = {adj, shift_q} << 1;

    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d   = bin;
          scratch_d = '0;
          cnt_d     = CNT_W'(WIDTH);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        {scratch_d, shift_d} = shifted;
        cnt_d                = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = shifted[BCD_W+WIDTH-1:WIDTH];
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      scratch_q <= '0;
      bcd_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      bcd_q     <= bcd_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign bcd  = bcd_q;

endmodule
`default_nettype wire

// File: tb/tb_binary_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_binary_to_bcd_seq
// Brief    : Scoreboard bench for binary_to_bcd_seq (WIDTH=8, DIGITS=3).
// Revision : 1.0
// ============================================================================
module tb_binary_to_bcd_seq;

  localparam int W = 8;
  localparam int D = 3;

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   bin;
  logic           busy;
  logic           done;
  logic [4*D-1:0] bcd;

  int             n_checks = 0;
  int             n_errors = 0;
  int             mcnt     = 0;
  int             cyc      = 0;
  int             last_done = -1;
  bit             spacing_en = 1'b0;
  logic [4*D-1:0] hold_exp = '0;
  logic [4*D-1:0] exp_q[$];

  binary_to_bcd_seq #(.WIDTH(W), .DIGITS(D)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [4*D-1:0] to_bcd(input int v);
    logic [3:0] d0, d1, d2;
    d0 = 4'(v % 10);
    d1 = 4'((v / 10) % 10);
    d2 = 4'((v / 100) % 10);
    return {d2, d1, d0};
  endfunction

  // Reference timeline: 0 idle, W+1 on acceptance, counting down to 1 in the done cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mcnt     = 0;
      hold_exp = '0;
      exp_q.delete();
    end else begin
      cyc++;
      if (mcnt == 0 && start) begin
        exp_q.push_back(to_bcd(int'(bin)));
        mcnt = W + 1;
      end else if (mcnt > 0) begin
        mcnt--;
      end
    end
  end

  always @(negedge clk) begin
    check("busy", {31'b0, busy}, {31'b0, mcnt >= 2});
    check("done", {31'b0, done}, {31'b0, mcnt == 1});
    check("busy_done_excl", {31'b0, busy & done}, 32'd0);
    if (mcnt == 1 && exp_q.size() > 0) begin
      hold_exp = exp_q.pop_front();
      check("bcd_done", {20'b0, bcd}, {20'b0, hold_exp});
    end else begin
      check("bcd_hold", {20'b0, bcd}, {20'b0, hold_exp});
    end
    if (done) begin
      if (spacing_en && last_done >= 0)
        check("done_spacing", cyc - last_done, 32'd10);
      last_done = cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 40) begin
      step();
      n++;
    end
    if (!done) check(tag, {31'b0, done}, 32'd1);
  endtask

  task automatic convert(input int v);
    bin   = W'(v);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done("convert_timeout");
    step();
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (3) step();
    rst = 1'b0;
    step();

    convert(0);
    convert(255);
    convert(99);
    convert(100);

    // Continuous start: a new value is presented in each done cycle.
    spacing_en = 1'b1;
    last_done  = -1;
    start      = 1'b1;
    for (int v = 0; v < 256; v++) begin
      bin = W'(v);
      if (v > 0) step();
      wait_done("held_timeout");
    end
    start = 1'b0;
    spacing_en = 1'b0;
    repeat (3) step();

    // Extra start and bin change during SHIFT must not disturb the captured 173.
    bin   = 8'd173;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (2) step();
    bin   = 8'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    bin   = 8'd77;
    wait_done("ignore_timeout");
    repeat (3) step();

    // Asynchronous reset in the middle of converting 200.
    bin   = 8'd200;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_bcd", {20'b0, bcd}, 32'd0);
    step();
    rst = 1'b0;
    step();
    convert(42);
    check("bcd_after_rst", {20'b0, bcd}, 32'h042);

    repeat (3) step();
    check("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
